player_motion: RTL and testbench
================================

Name: player_motion

Overview:
- Upstream stage of the graphics renderer. Produces player_x, player_y and player_direction for the sprite blob.
- Once per video frame, on the vsync falling edge, it reads the directional buttons, proposes a one-step move and checks it against the object grid and playfield bounds.
- It commits or rejects the move through a small multi-cycle FSM.
- Outputs are registered and stable for the whole visible frame.

Parameters:
- ORIGIN_X, 112, playfield left edge in pixels
- ORIGIN_Y, 112, playfield top edge in pixels
- TILE_LOG2, 5, tile size is 2^TILE_LOG2 (32 px); sprite is one tile square
- COLS, 13, grid columns
- ROWS, 8, grid rows
- SPEED, 2, pixels moved per accepted frame
- SPAWN_COL, 6, spawn tile column
- SPAWN_ROW, 4, spawn tile row
- PLAY_STATE, 3'd1, game_state value meaning "playing"

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- vsync_in  in  1  XVGA vsync, active low
- game_state  in  3  global game state
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, level-sensitive
- object_grid  in  8x13x4 packed  object_grid[row][col]; 0 = walkable, nonzero = blocking
- player_x  out  9  sprite left edge, absolute pixel
- player_y  out  9  sprite top edge, absolute pixel
- player_direction  out  2  0 up, 1 down, 2 left, 3 right
- move_done  out  1  one-cycle pulse when a frame's evaluation commits

Behaviour:
- Reset values:
  - player_x = ORIGIN_X + SPAWN_COL<<TILE_LOG2 (304)
  - player_y = ORIGIN_Y + SPAWN_ROW<<TILE_LOG2 (240)
  - player_direction = 1
  - move_done = 0
  - FSM = IDLE
- Frame tick: vsync_in is registered each cycle. A tick is a clock edge where vsync_in is sampled 0 and the previous sample was 1.
- FSM states: IDLE -> CALC -> CHK0 -> CHK1 -> COMMIT -> IDLE.
  - IDLE -> CALC: on a tick, only when game_state == PLAY_STATE and at least one button is held. Otherwise remain in IDLE with no change and no move_done.
  - CALC: choose a single direction by priority up > down > left > right. Form candidate x'/y' = position ± SPEED in 11-bit signed arithmetic (no wrap).
  - CHK0/CHK1: test the two leading corners of the candidate box, one per cycle. Tile index = (p - ORIGIN) >> TILE_LOG2. Leading corners per direction:
    - up: (x', y') and (x'+31, y')
    - down: (x', y'+31) and (x'+31, y'+31)
    - left: (x', y) and (x', y+31)
    - right: (x'+31, y) and (x'+31, y+31)
  - Blocking: a corner blocks if it lies outside [ORIGIN, ORIGIN + COLS/ROWS·tile − 1] or if its tile is nonzero.
  - COMMIT:
    - player_direction always takes the chosen direction, even if blocked.
    - Position updates only if neither corner blocked.
    - move_done = 1 for this cycle only.
- Latency: outputs update and move_done asserts on the 4th clock edge after the tick edge. The FSM is never left partially committed.
- Ticks arriving while not in IDLE are ignored.
- Entering play: a transition of game_state into PLAY_STATE from any other value reloads the spawn position and direction 1 on the next edge. This takes priority over the FSM, which returns to IDLE.
- game_state leaving PLAY_STATE mid-evaluation: abort to IDLE, no commit, no move_done.
- Reset mid-evaluation: outputs take reset values on that edge; no move_done.
- Simultaneous opposite buttons: resolved by priority only (up+down moves up).

Optional Feature:
- Macro: COLLISION_COUNT_EN.
- Defined:
  - Adds output bump_count (8 bits, reset 0).
  - Increments in COMMIT whenever the move was blocked; saturates at 255.
  - Cleared on entry to PLAY_STATE.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset, then release -> player_x=304, player_y=240, player_direction=1, move_done=0; ticks with no buttons -> no move_done.
- game_state=1, empty grid, btn_right held, 3 vsync falling edges -> move_done pulses 4 cycles after each tick; x=306, 308, 310; y=240; direction=3.
- object_grid[4][7]=2, player at (304,240), btn_right -> candidate right edge 337 maps to col 7, blocked; x stays 304, direction=3, move_done pulses (bump_count=1 if enabled).
- Empty grid, btn_left for 97 frames from spawn -> x reaches 112 after 96 frames; 97th frame blocked, x stays 112, no underflow.
- btn_up+btn_right held one frame -> y=238, x unchanged, direction=0.
- Assert reset during CHK0 -> next edge spawn values, no move_done. Set game_state 1->0->1 after moves -> position back to (304,240); ticks while game_state=0 produce no change.

Source files
------------

// File: rtl/player_motion.sv
// Per-frame player movement: reads the buttons on each vsync falling edge, then checks the move against the grid and the playfield bounds.
// Define COLLISION_COUNT_EN to add the saturating bump_count output.
module player_motion #(
   parameter int         ORIGIN_X   = 112,
   parameter int         ORIGIN_Y   = 112,
   parameter int         TILE_LOG2  = 5,
   parameter int         COLS       = 13,
   parameter int         ROWS       = 8,
   parameter int         SPEED      = 2,
   parameter int         SPAWN_COL  = 6,
   parameter int         SPAWN_ROW  = 4,
   parameter logic [2:0] PLAY_STATE = 3'd1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             vsync_in,
   input  logic [2:0]                       game_state,
   input  logic                             btn_up,
   input  logic                             btn_down,
   input  logic                             btn_left,
   input  logic                             btn_right,
   input  logic [ROWS-1:0][COLS-1:0][3:0]   object_grid,
   output logic [8:0]                       player_x,
   output logic [8:0]                       player_y,
   output logic [1:0]                       player_direction,
   output logic                             move_done
`ifdef COLLISION_COUNT_EN
   ,
   output logic [7:0]                       bump_count
`endif
);

   localparam int TILE = 1 << TILE_LOG2;
   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);

   localparam logic signed [10:0] X_LO = 11'(ORIGIN_X);
   localparam logic signed [10:0] X_HI = 11'(ORIGIN_X + COLS * TILE - 1);
   localparam logic signed [10:0] Y_LO = 11'(ORIGIN_Y);
   localparam logic signed [10:0] Y_HI = 11'(ORIGIN_Y + ROWS * TILE - 1);
   localparam logic signed [10:0] EDGE = 11'(TILE - 1);
   localparam logic signed [10:0] ZERO = 11'(0);
   localparam logic signed [10:0] SPD  = 11'(SPEED);

   localparam logic [8:0] SPAWN_X = 9'(ORIGIN_X + (SPAWN_COL << TILE_LOG2));
   localparam logic [8:0] SPAWN_Y = 9'(ORIGIN_Y + (SPAWN_ROW << TILE_LOG2));

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [2:0] {IDLE, CALC, CHK0, CHK1, COMMIT} state_t;

   state_t              state_q, state_d;
   logic                vsync_q;
   logic [2:0]          gs_q;
   logic [3:0]          btn_q, btn_d;
   logic [1:0]          dir_q, dir_d;
   logic signed [10:0]  cx_q, cx_d, cy_q, cy_d;
   logic                blk_q, blk_d;
   logic [8:0]          x_q, x_d, y_q, y_d;
   logic [1:0]          pdir_q, pdir_d;
   logic                done_q, done_d;
`ifdef COLLISION_COUNT_EN
   logic [7:0]          bump_q, bump_d;
`endif

   logic                tick, playing, enterPlay;
   logic signed [10:0]  c0x, c0y, c1x, c1y, baseX, baseY;

   assign tick      = vsync_q & ~vsync_in;
   assign playing   = (game_state == PLAY_STATE);
   assign enterPlay = playing && (gs_q != PLAY_STATE);
   assign baseX     = signed'({2'b00, x_q});
   assign baseY     = signed'({2'b00, y_q});

   // Leading-edge corners of the candidate box for the chosen direction.
   assign c0x = cx_q + ((dir_q == DIR_RIGHT) ? EDGE : ZERO);
   assign c0y = cy_q + ((dir_q == DIR_DOWN)  ? EDGE : ZERO);
   assign c1x = cx_q + ((dir_q == DIR_LEFT)  ? ZERO : EDGE);
   assign c1y = cy_q + ((dir_q == DIR_UP)    ? ZERO : EDGE);

   function automatic logic cornerBlocked(input logic signed [10:0] px,
                                          input logic signed [10:0] py);
      logic [10:0]   dx, dy;
      logic [CW-1:0] col;
      logic [RW-1:0] row;
      dx  = px - X_LO;
      dy  = py - Y_LO;
      col = CW'(dx >> TILE_LOG2);
      row = RW'(dy >> TILE_LOG2);
      if (px < X_LO || px > X_HI || py < Y_LO || py > Y_HI)
         cornerBlocked = 1'b1;
      else
         cornerBlocked = (object_grid[row][col] != 4'd0);
   endfunction

   always_comb begin
      state_d = state_q;
      btn_d   = btn_q;
      dir_d   = dir_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      blk_d   = blk_q;
      x_d     = x_q;
      y_d     = y_q;
      pdir_d  = pdir_q;
      done_d  = 1'b0;
`ifdef COLLISION_COUNT_EN
      bump_d  = bump_q;
`endif
      if (enterPlay) begin
         state_d = IDLE;
         x_d     = SPAWN_X;
         y_d     = SPAWN_Y;
         pdir_d  = DIR_DOWN;
`ifdef COLLISION_COUNT_EN
         bump_d  = 8'd0;
`endif
      end else if (state_q != IDLE && !playing) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick && playing && (btn_up | btn_down | btn_left | btn_right)) begin
                  btn_d   = {btn_right, btn_left, btn_down, btn_up};
                  state_d = CALC;
               end
            end
            CALC: begin
               cx_d = baseX;
               cy_d = baseY;
               if (btn_q[0]) begin
                  dir_d = DIR_UP;
                  cy_d  = baseY - SPD;
               end else if (btn_q[1]) begin
                  dir_d = DIR_DOWN;
                  cy_d  = baseY + SPD;
               end else if (btn_q[2]) begin
                  dir_d = DIR_LEFT;
                  cx_d  = baseX - SPD;
               end else begin
                  dir_d = DIR_RIGHT;
                  cx_d  = baseX + SPD;
               end
               state_d = CHK0;
            end
            CHK0: begin
               blk_d   = cornerBlocked(c0x, c0y);
               state_d = CHK1;
            end
            CHK1: begin
               blk_d   = blk_q | cornerBlocked(c1x, c1y);
               state_d = COMMIT;
            end
            COMMIT: begin
               pdir_d = dir_q;
               done_d = 1'b1;
               if (!blk_q) begin
                  x_d = cx_q[8:0];
                  y_d = cy_q[8:0];
               end
`ifdef COLLISION_COUNT_EN
               else if (bump_q != 8'hFF) begin
                  bump_d = bump_q + 8'd1;
               end
`endif
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Edge-detect samples are free-running so reset release never fakes a tick or a play entry.
   always_ff @(posedge clock) begin
      vsync_q <= vsync_in;
      gs_q    <= game_state;
      if (reset) begin
         state_q <= IDLE;
         btn_q   <= 4'd0;
         dir_q   <= DIR_DOWN;
         cx_q    <= '0;
         cy_q    <= '0;
         blk_q   <= 1'b0;
         x_q     <= SPAWN_X;
         y_q     <= SPAWN_Y;
         pdir_q  <= DIR_DOWN;
         done_q  <= 1'b0;
`ifdef COLLISION_COUNT_EN
         bump_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         btn_q   <= btn_d;
         dir_q   <= dir_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         blk_q   <= blk_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pdir_q  <= pdir_d;
         done_q  <= done_d;
`ifdef COLLISION_COUNT_EN
         bump_q  <= bump_d;
`endif
      end
   end

   assign player_x         = x_q;
   assign player_y         = y_q;
   assign player_direction = pdir_q;
   assign move_done        = done_q;
`ifdef COLLISION_COUNT_EN
   assign bump_count       = bump_q;
`endif

endmodule

// File: tb/tb_player_motion.sv
// Directed plus randomized bench for player_motion against a whole-box collision model.
module tb_player_motion;

   logic                      clock = 1'b0;
   logic                      reset;
   logic                      vsyncIn;
   logic [2:0]                gameState;
   logic                      bUp, bDown, bLeft, bRight;
   logic [7:0][12:0][3:0]     grid;
   logic [8:0]                playerX, playerY;
   logic [1:0]                playerDir;
   logic                      moveDone;
`ifdef COLLISION_COUNT_EN
   logic [7:0]                bumpCount;
`endif

   int errors = 0;
   int checks = 0;
   int mx, my, mdir, mbump;

   player_motion dut (
      .clock(clock), .reset(reset), .vsync_in(vsyncIn), .game_state(gameState),
      .btn_up(bUp), .btn_down(bDown), .btn_left(bLeft), .btn_right(bRight),
      .object_grid(grid),
      .player_x(playerX), .player_y(playerY), .player_direction(playerDir),
      .move_done(moveDone)
`ifdef COLLISION_COUNT_EN
      , .bump_count(bumpCount)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, " x"}, 32'(playerX), 32'(mx));
      checkOutput({tag, " y"}, 32'(playerY), 32'(my));
      checkOutput({tag, " dir"}, 32'(playerDir), 32'(mdir));
`ifdef COLLISION_COUNT_EN
      checkOutput({tag, " bump"}, 32'(bumpCount), 32'(mbump));
`endif
   endtask

   task automatic modelSpawn();
      mx = 112 + 6 * 32;
      my = 112 + 4 * 32;
      mdir = 1;
      mbump = 0;
   endtask

   // Candidate box blocks if any of its pixels leave the field or touch a nonzero tile.
   function automatic bit boxBlocked(int bx, int by);
      if (bx < 112 || bx + 31 > 112 + 13 * 32 - 1 || by < 112 || by + 31 > 112 + 8 * 32 - 1)
         return 1'b1;
      for (int r = (by - 112) / 32; r <= (by + 31 - 112) / 32; r++)
         for (int c = (bx - 112) / 32; c <= (bx + 31 - 112) / 32; c++)
            if (grid[r][c] != 4'd0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelStep();
      int nx, ny;
      nx = mx;
      ny = my;
      if (bUp)        begin mdir = 0; ny = my - 2; end
      else if (bDown) begin mdir = 1; ny = my + 2; end
      else if (bLeft) begin mdir = 2; nx = mx - 2; end
      else            begin mdir = 3; nx = mx + 2; end
      if (boxBlocked(nx, ny)) begin
         if (mbump < 255) mbump++;
      end else begin
         mx = nx;
         my = ny;
      end
   endtask

   task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r);
      @(negedge clock);
      bUp = u; bDown = d; bLeft = l; bRight = r;
   endtask

   task automatic runFrame(input string tag);
      bit         expectMove;
      logic [5:0] seen;
      logic [5:0] want;
      expectMove = (gameState == 3'd1) && (bUp || bDown || bLeft || bRight);
      if (expectMove) modelStep();
      @(negedge clock);
      vsyncIn = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         seen[k] = moveDone;
      end
      vsyncIn = 1'b1;
      @(negedge clock);
      @(negedge clock);
      want = expectMove ? 6'b010000 : 6'b000000;
      checkOutput({tag, " move_done timing"}, 32'(seen), 32'(want));
      checkAll(tag);
   endtask

   task automatic enterPlay();
      @(negedge clock);
      gameState = 3'd0;
      @(negedge clock);
      @(negedge clock);
      gameState = 3'd1;
      @(negedge clock);
      @(negedge clock);
      modelSpawn();
   endtask

   initial begin
      logic [3:0] rb;
      logic [5:0] seen;
      reset = 1'b1; vsyncIn = 1'b1; gameState = 3'd0;
      bUp = 0; bDown = 0; bLeft = 0; bRight = 0;
      grid = '0;
      modelSpawn();
      repeat (3) @(negedge clock);
      checkAll("in reset");
      checkOutput("in reset move_done", 32'(moveDone), 0);
      reset = 1'b0;
      @(negedge clock);
      checkAll("after reset");
      checkOutput("after reset move_done", 32'(moveDone), 0);
      runFrame("idle no play");
      enterPlay();
      runFrame("no buttons");

      applyStimulus(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) runFrame("right empty");
      checkOutput("right x after 3", 32'(playerX), 310);

      grid[4][7] = 4'd2;
      enterPlay();
      runFrame("right blocked");
      checkOutput("blocked x held", 32'(playerX), 304);
`ifdef COLLISION_COUNT_EN
      checkOutput("blocked bump", 32'(bumpCount), 1);
`endif

      grid = '0;
      enterPlay();
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 96; i++) runFrame("left walk");
      checkOutput("left reaches edge", 32'(playerX), 112);
      runFrame("left at edge");
      checkOutput("left no underflow", 32'(playerX), 112);

      applyStimulus(1, 0, 0, 1);
      runFrame("up+right");
      checkOutput("up+right y", 32'(playerY), 238);

      applyStimulus(1, 1, 0, 0);
      runFrame("up+down");

      applyStimulus(0, 1, 0, 0);
      @(negedge clock);
      vsyncIn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      modelSpawn();
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         seen[k] = moveDone;
      end
      checkAll("reset mid-eval");
      checkOutput("reset mid-eval move_done", 32'(seen[3:0]), 0);
      reset = 1'b0;
      vsyncIn = 1'b1;
      repeat (2) @(negedge clock);

      applyStimulus(0, 0, 0, 1);
      runFrame("pre-exit right");
      runFrame("pre-exit right");
      @(negedge clock);
      gameState = 3'd0;
      runFrame("not playing");
      runFrame("not playing");
      @(negedge clock);
      gameState = 3'd1;
      @(negedge clock);
      @(negedge clock);
      modelSpawn();
      checkAll("re-enter play");

      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 13; c++)
            grid[r][c] = ($urandom_range(0, 99) < 15) ? 4'($urandom_range(1, 15)) : 4'd0;
      grid[4][6] = 4'd0;
      enterPlay();
      for (int i = 0; i < 40; i++) begin
         rb = 4'($urandom_range(0, 15));
         applyStimulus(rb[0], rb[1], rb[2], rb[3]);
         runFrame("random");
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
